// File: rtl/kernel_dispatcher_if.sv
// Launch handshake, core control and status bundle between host, dispatcher and core array.
// master = host/core side, slave = dispatcher side.
interface kernel_dispatcher_if #(
  parameter int NUM_CORES  = 1,
  parameter int DATA_WIDTH = 32
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] base_instr;
    logic [DATA_WIDTH-1:0] base_data;
    logic [DATA_WIDTH-1:0] num_blocks;
    logic [DATA_WIDTH-1:0] warps_per_block;
  } kernel_config_t;

  logic                                  kernel_valid;
  logic                                  kernel_ready;
  logic [DATA_WIDTH-1:0]                 kernel_base_instr;
  logic [DATA_WIDTH-1:0]                 kernel_base_data;
  logic [DATA_WIDTH-1:0]                 kernel_num_blocks;
  logic [DATA_WIDTH-1:0]                 kernel_warps_per_block;
  logic                                  abort;
  kernel_config_t                        kernel_config;
  logic [NUM_CORES-1:0]                  core_done;
  logic [NUM_CORES-1:0]                  core_start;
  logic [NUM_CORES-1:0]                  core_reset;
  logic [NUM_CORES-1:0][DATA_WIDTH-1:0]  core_block_id;
  logic                                  kernel_done;
  logic                                  kernel_aborted;
  logic                                  busy;

  modport master (
    output kernel_valid, kernel_base_instr, kernel_base_data, kernel_num_blocks,
           kernel_warps_per_block, abort, core_done,
    input  kernel_ready, kernel_config, core_start, core_reset, core_block_id,
           kernel_done, kernel_aborted, busy
  );

  modport slave (
    input  kernel_valid, kernel_base_instr, kernel_base_data, kernel_num_blocks,
           kernel_warps_per_block, abort, core_done,
    output kernel_ready, kernel_config, core_start, core_reset, core_block_id,
           kernel_done, kernel_aborted, busy
  );
endinterface

// File: rtl/kernel_dispatcher.sv
// Queued kernel dispatcher: launch FIFO, top-level kernel FSM and one small FSM per core
// that hands out block IDs round-robin and counts completions.
module kernel_dispatcher #(
  parameter int NUM_CORES  = 1,
  parameter int KQ_DEPTH   = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  kernel_dispatcher_if.slave kif
);
  localparam int AW    = $clog2(KQ_DEPTH);
  localparam int RW    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CFG_W = 4 * DATA_WIDTH;

  typedef enum logic [2:0] {T_IDLE, T_LOAD, T_DISPATCH, T_DRAIN, T_DONE} top_state_t;
  typedef enum logic [1:0] {C_IDLE, C_SETUP, C_RUN} core_state_t;

  top_state_t                           state_q, state_d;
  core_state_t                          cst_q [NUM_CORES];
  core_state_t                          cst_d [NUM_CORES];
  logic [CFG_W-1:0]                     kq_mem [KQ_DEPTH];
  logic [AW:0]                          wr_ptr_q, rd_ptr_q;
  logic [CFG_W-1:0]                     cfg_q;
  logic [DATA_WIDTH-1:0]                next_blk_q, next_blk_d;
  logic [DATA_WIDTH-1:0]                done_cnt_q, done_cnt_d;
  logic [DATA_WIDTH-1:0]                done_inc, num_blocks;
  logic [RW-1:0]                        rr_q, rr_d, pick;
  logic [RW:0]                          pick_res;
  logic [NUM_CORES-1:0][DATA_WIDTH-1:0] blk_id_q, blk_id_d;
  logic [NUM_CORES-1:0]                 idle_mask;
  logic                                 aborted_q, aborted_d;
  logic                                 full, empty, push, pop, abort_ok;

  // Returns {found, index} of the first idle core at or after rr, wrapping around.
  function automatic logic [RW:0] first_idle(input logic [NUM_CORES-1:0] idle,
                                             input logic [RW-1:0] rr);
    logic [RW:0] res;
    int          idx;
    res = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      idx = int'(rr) + i;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (idle[idx]) res = {1'b1, RW'(idx)};
    end
    return res;
  endfunction

  assign full       = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
  assign empty      = wr_ptr_q == rd_ptr_q;
  assign push       = kif.kernel_valid && !full;
  assign pop        = (state_q == T_IDLE) && !empty;
  assign num_blocks = cfg_q[DATA_WIDTH +: DATA_WIDTH];
  assign abort_ok   = kif.abort && (state_q inside {T_LOAD, T_DISPATCH, T_DRAIN});
  assign pick_res   = first_idle(idle_mask, rr_q);
  assign pick       = pick_res[RW-1:0];

  always_comb begin
    state_d    = state_q;
    cst_d      = cst_q;
    next_blk_d = next_blk_q;
    rr_d       = rr_q;
    blk_id_d   = blk_id_q;
    aborted_d  = 1'b0;
    done_inc   = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (cst_q[c] == C_SETUP) begin
        cst_d[c] = C_RUN;
      end else if (cst_q[c] == C_RUN && kif.core_done[c]) begin
        cst_d[c] = C_IDLE;
        done_inc = done_inc + 1'b1;
      end
    end
    done_cnt_d = done_cnt_q + done_inc;

    if (abort_ok) begin
      state_d   = T_IDLE;
      aborted_d = 1'b1;
      for (int c = 0; c < NUM_CORES; c++) cst_d[c] = C_IDLE;
    end else begin
      case (state_q)
        T_IDLE: begin
          if (!empty) begin
            state_d    = T_LOAD;
            next_blk_d = '0;
            done_cnt_d = '0;
          end
        end
        T_LOAD: state_d = (num_blocks == '0) ? T_DONE : T_DISPATCH;
        T_DISPATCH: begin
          if (pick_res[RW]) begin
            cst_d[pick]    = C_SETUP;
            blk_id_d[pick] = next_blk_q;
            next_blk_d     = next_blk_q + 1'b1;
            rr_d           = (int'(pick) == NUM_CORES - 1) ? '0 : pick + 1'b1;
            if (next_blk_d == num_blocks) state_d = T_DRAIN;
          end
        end
        T_DRAIN: if (done_cnt_q == num_blocks) state_d = T_DONE;
        T_DONE:  state_d = T_IDLE;
        default: state_d = T_IDLE;
      endcase
    end
  end

  // FIFO storage carries no reset; the pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (push) kq_mem[wr_ptr_q[AW-1:0]] <= {kif.kernel_base_instr, kif.kernel_base_data,
                                           kif.kernel_num_blocks, kif.kernel_warps_per_block};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= T_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cfg_q      <= '0;
      next_blk_q <= '0;
      done_cnt_q <= '0;
      rr_q       <= '0;
      blk_id_q   <= '0;
      aborted_q  <= 1'b0;
      for (int c = 0; c < NUM_CORES; c++) cst_q[c] <= C_IDLE;
    end else begin
      state_q    <= state_d;
      next_blk_q <= next_blk_d;
      done_cnt_q <= done_cnt_d;
      rr_q       <= rr_d;
      blk_id_q   <= blk_id_d;
      aborted_q  <= aborted_d;
      for (int c = 0; c < NUM_CORES; c++) cst_q[c] <= cst_d[c];
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        cfg_q    <= kq_mem[rd_ptr_q[AW-1:0]];
      end
    end
  end

  assign kif.kernel_ready   = !full;
  assign kif.kernel_config  = cfg_q;
  assign kif.core_block_id  = blk_id_q;
  assign kif.kernel_done    = state_q == T_DONE;
  assign kif.kernel_aborted = aborted_q;
  assign kif.busy           = state_q != T_IDLE;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    assign idle_mask[g]      = cst_q[g] == C_IDLE;
    assign kif.core_reset[g] = cst_q[g] == C_IDLE;
    assign kif.core_start[g] = cst_q[g] == C_RUN;
  end
endmodule
